// File: rtl/ahb_arbiter_if.sv
// AHB arbitration bundle: requests and owner's transfer info in, grant and owner indices out.
interface ahb_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [3:0]             HMASTER;
  logic                   HMASTLOCK;
  logic [3:0]             HMASTER_DATA;

  // Bus side: drives requests and the muxed transfer controls.
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK, HMASTER_DATA
  );

  // Arbiter side.
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK, HMASTER_DATA
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter. Grants change only at arbitration points; fixed-length
// bursts and locked sequences keep the current owner. All outputs are registered.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  localparam logic [1:0] DefIdx   = 2'(DEFAULT_MASTER);
  localparam logic [3:0] DefGrant = 4'b0001 << DefIdx;

  typedef enum logic [0:0] {StArb, StBurst} state_e;

  state_e                 st_q, st_d;
  logic [3:0]             bcnt_q, bcnt_d;
  logic [1:0]             rr_q, rr_d;
  logic [1:0]             hmaster_q, hmaster_d;
  logic [1:0]             hmaster_data_q, hmaster_data_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;

  // Requests padded to the maximum of four masters so 2-bit indices are always in range.
  logic [3:0] req4, lock4;
  assign req4  = 4'(bus.HBUSREQ);
  assign lock4 = 4'(bus.HLOCK);

  logic [4:0] blen;

  // Decode the number of beats implied by HBURST (INCR counts as 1: arbitrable every beat).
  always_comb begin
    case (bus.HBURST)
      3'b000, 3'b001: blen = 5'd1;
      3'b010, 3'b011: blen = 5'd4;
      3'b100, 3'b101: blen = 5'd8;
      default:        blen = 5'd16;
    endcase
  end

  logic [1:0]  win_idx, win_rr, cand;
  logic        win_lock, found;
  int unsigned sum;

  // Winner if this edge is an arbitration point: locked owner keeps the bus, otherwise
  // the first other requester after RR wins, owner only when it is the sole requester.
  always_comb begin
    win_idx = DefIdx;
    win_rr  = rr_q;
    found   = 1'b0;
    cand    = '0;
    sum     = 0;
    if (lock4[hmaster_q]) begin
      win_idx = hmaster_q;
    end else begin
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
        sum = 32'(rr_q) + i;
        if (sum >= NUM_MASTERS) begin
          sum = sum - NUM_MASTERS;
        end
        cand = sum[1:0];
        if (!found && (cand != hmaster_q) && req4[cand]) begin
          win_idx = cand;
          win_rr  = cand;
          found   = 1'b1;
        end
      end
      if (!found && req4[hmaster_q]) begin
        win_idx = hmaster_q;
        win_rr  = hmaster_q;
      end
    end
    win_lock = lock4[win_idx];
  end

  logic       arb_pt;
  logic [3:0] grant4;

  // Next-state: burst tracking, arbitration-point detection and owner pipeline.
  always_comb begin
    st_d           = st_q;
    bcnt_d         = bcnt_q;
    rr_d           = rr_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    hmastlock_d    = hmastlock_q;
    arb_pt         = 1'b0;
    grant4         = '0;
    hgrant_d       = hgrant_q;

    if (bus.HREADY) begin
      hmaster_data_d = hmaster_q;
      unique case (st_q)
        StArb: begin
          if ((bus.HTRANS == TrNonseq) && (blen > 5'd1)) begin
            bcnt_d = 4'(blen - 5'd1);
            st_d   = StBurst;
          end else begin
            arb_pt = 1'b1;
          end
        end
        StBurst: begin
          unique case (bus.HTRANS)
            TrSeq: begin
              if (bcnt_q <= 4'd1) begin
                bcnt_d = '0;
                st_d   = StArb;
                arb_pt = 1'b1;
              end else begin
                bcnt_d = bcnt_q - 4'd1;
              end
            end
            TrBusy: begin
              bcnt_d = bcnt_q;
            end
            TrIdle: begin
              bcnt_d = '0;
              st_d   = StArb;
              arb_pt = 1'b1;
            end
            TrNonseq: begin
              if (blen > 5'd1) begin
                bcnt_d = 4'(blen - 5'd1);
              end else begin
                bcnt_d = '0;
                st_d   = StArb;
                arb_pt = 1'b1;
              end
            end
            default: bcnt_d = bcnt_q;
          endcase
        end
        default: st_d = StArb;
      endcase

      if (arb_pt) begin
        hmaster_d   = win_idx;
        rr_d        = win_rr;
        hmastlock_d = win_lock;
      end
    end

    grant4   = 4'b0001 << hmaster_d;
    hgrant_d = grant4[NUM_MASTERS-1:0];
  end

  // State and registered outputs; HREADY low leaves every _d equal to its _q.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_q           <= StArb;
      bcnt_q         <= '0;
      rr_q           <= DefIdx;
      hmaster_q      <= DefIdx;
      hmaster_data_q <= DefIdx;
      hmastlock_q    <= 1'b0;
      hgrant_q       <= DefGrant[NUM_MASTERS-1:0];
    end else begin
      st_q           <= st_d;
      bcnt_q         <= bcnt_d;
      rr_q           <= rr_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
      hgrant_q       <= hgrant_d;
    end
  end

  assign bus.HGRANT       = hgrant_q;
  assign bus.HMASTER      = {2'b00, hmaster_q};
  assign bus.HMASTLOCK    = hmastlock_q;
  assign bus.HMASTER_DATA = {2'b00, hmaster_data_q};

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Multi-master AHB bus arbiter that shares the single AHB address/data path, and the slave select logic behind it, between the CPU and the DMA engine (NUM_MASTERS requesters). It grants the bus round-robin at legal arbitration points, protects fixed-length bursts and locked sequences from preemption, and drives HMASTER / HMASTER_DATA for the master-side address and write-data multiplexers. It sits between the masters and the address mux feeding the AHB decoder.

## Interface
- NUM_MASTERS, 2, number of requesters (2..4); index 0 = CPU, 1 = DMA.
- DEFAULT_MASTER, 0, master granted when nobody requests; also reset owner.
- HCLK  input  1  AHB clock; all state updates on the rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- HBUSREQ  input  NUM_MASTERS  per-master bus request.
- HLOCK  input  NUM_MASTERS  per-master lock request.
- HTRANS  input  2  muxed transfer type of current owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURST  input  3  muxed burst type of current owner.
- HREADY  input  1  bus ready; a transfer is accepted at an edge with HREADY=1.
- HGRANT  output  NUM_MASTERS  one-hot grant, registered.
- HMASTER  output  4  index of address-phase owner, registered.
- HMASTLOCK  output  1  current address phase is locked, registered.
- HMASTER_DATA  output  4  index of data-phase owner, registered.

## Operation
- FSM states: ARB (no fixed burst in progress), BURST (fixed burst in progress). 4-bit beat counter BCNT; round-robin pointer RR (last granted index).
- Burst length from HBURST: SINGLE=1, INCR=1 (undefined length, arbitrable every beat), WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
- All state changes only at edges with HREADY=1; HREADY=0 freezes every register.
- Accepted transfer handling (HREADY=1):
  - ARB, NONSEQ with length L>1: BCNT<=L-1, go BURST, no arbitration.
  - ARB, IDLE / NONSEQ with L=1 / SEQ / BUSY: arbitration point.
  - BURST, SEQ: BCNT<=BCNT-1; if BCNT was 1 -> arbitration point, go ARB.
  - BURST, BUSY: hold.
  - BURST, IDLE (early termination): arbitration point, go ARB, BCNT<=0.
  - BURST, NONSEQ: reload BCNT per new HBURST, stay BURST (L=1 -> arbitration point, go ARB).
- Arbitration point:
  - Owner HLOCK=1: owner retains grant, HMASTLOCK<=1.
  - Else search HBUSREQ from RR+1 upward, wrapping modulo NUM_MASTERS; first requester wins (owner wins only if sole requester); RR<=winner.
  - No requester: grant DEFAULT_MASTER, RR unchanged.
  - HMASTLOCK<=HLOCK[winner].
- On every accepted edge: HMASTER_DATA<=HMASTER (old value); HMASTER<=winner index when arbitrating, else unchanged. HGRANT always one-hot of HMASTER.
- Grant is never removed from owner inside BURST or while locked, regardless of other requests.

## Timing
- Reset (HRESETn=0, asynchronous): HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTER_DATA=DEFAULT_MASTER, HMASTLOCK=0, state ARB, BCNT=0, RR=DEFAULT_MASTER. Reset mid-burst aborts immediately.
- Latency: request sampled at an arbitration edge -> HGRANT/HMASTER valid the following cycle (1 cycle); HMASTER_DATA trails HMASTER by one accepted transfer.
- Simultaneous HBUSREQ change and arbitration point: value sampled at that edge is used.
- Outputs purely registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert HRESETn=0 mid-burst, DEFAULT_MASTER=0 -> HGRANT=01, HMASTER=0, HMASTLOCK=0, HMASTER_DATA=0 without a clock edge.
- Round-robin: HBUSREQ=11, single NONSEQ transfers, HREADY=1 -> HMASTER alternates 0,1,0,1; HMASTER_DATA follows one cycle later.
- Burst protection: master 0 NONSEQ INCR4 then 3 SEQ, master 1 requesting throughout -> HGRANT stays 01 for all 4 beats, becomes 10 the cycle after the 4th beat's address is accepted.
- Wait states: HREADY=0 for 3 cycles during WRAP8 beat 2 -> BCNT, HGRANT, HMASTER unchanged; burst still completes 8 beats before handover.
- Lock: master 1 HLOCK=1 with two singles, master 0 requesting -> grant held by 1, HMASTLOCK=1; after HLOCK drops, next arbitration grants 0, HMASTLOCK=0.
- Early termination/idle: master 0 INCR8 then IDLE after beat 3 -> re-arbitration that edge; HBUSREQ=00 -> grant returns to DEFAULT_MASTER.
